// File: rtl/hud_pkg.sv
// Shared constants and field descriptor types for the HUD overlay generator.
package hud_pkg;

    localparam int unsigned BORDER_X0_DEF = 53;
    localparam int unsigned BORDER_X1_DEF = 683;
    localparam int unsigned BORDER_Y0_DEF = 38;
    localparam int unsigned BORDER_Y1_DEF = 453;
    localparam int unsigned BORDER_W_DEF  = 5;
    localparam int unsigned TEXT_Y0_DEF   = 460;
    localparam int unsigned TEXT_H_DEF    = 16;

    localparam int unsigned XS_W   = 10;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned BASE_W = 8;

    localparam int unsigned ROM_X_W = 8;
    localparam int unsigned ROM_Y_W = 4;

    localparam int unsigned TIME_X_START   = 108;
    localparam int unsigned TIME_LEN       = 63;
    localparam int unsigned TIME_ROM_BASE  = 0;
    localparam int unsigned SCORE_X_START  = 362;
    localparam int unsigned SCORE_LEN      = 81;
    localparam int unsigned SCORE_ROM_BASE = 62;

    typedef struct packed {
        logic [XS_W-1:0]   x_start;
        logic [LEN_W-1:0]  len;
        logic [BASE_W-1:0] rom_base;
    } field_desc_t;

    // Exclusive end column, one bit wider so start+len never wraps.
    function automatic logic [XS_W:0] field_end(input logic [XS_W-1:0]  x_start,
                                                input logic [LEN_W-1:0] len);
        return {1'b0, x_start} + {{(XS_W - LEN_W + 1){1'b0}}, len};
    endfunction

endpackage

// File: rtl/hud_overlay_gen_if.sv
// Glyph ROM bus: address out to the ROM, one pixel bit back.
interface hud_overlay_gen_if;
    import hud_pkg::*;

    logic [ROM_X_W-1:0] x_count;
    logic [ROM_Y_W-1:0] y_count;
    logic               data;

    modport master (output x_count, output y_count, input data);
    modport slave  (input x_count, input y_count, output data);

endinterface

// File: rtl/hud_blink_ctr.sv
// Frame-start detector, frame counter and blink phase toggle.
module hud_blink_ctr #(
    parameter int unsigned PW           = 10,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic          clock_25,
    input  logic          reset,
    input  logic [PW-1:0] x_i,
    input  logic [PW-1:0] y_i,
    output logic          blink_phase_o
);

    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(BLINK_FRAMES - 1);

    logic          frame_start;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign frame_start = (x_i == '0) && (y_i == '0);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;

endmodule

// File: rtl/hud_overlay_gen.sv
// Playfield border and HUD text overlay: ROM address generation and latency-matched overlay bit.
module hud_overlay_gen
    import hud_pkg::*;
#(
    parameter int unsigned PIXEL_DISPLAY_BIT = 9,
    parameter int unsigned N_FIELDS          = 2,
    parameter int unsigned ROM_LATENCY       = 1,
    parameter int unsigned BORDER_X0         = BORDER_X0_DEF,
    parameter int unsigned BORDER_X1         = BORDER_X1_DEF,
    parameter int unsigned BORDER_Y0         = BORDER_Y0_DEF,
    parameter int unsigned BORDER_Y1         = BORDER_Y1_DEF,
    parameter int unsigned BORDER_W          = BORDER_W_DEF,
    parameter int unsigned TEXT_Y0           = TEXT_Y0_DEF,
    parameter int unsigned TEXT_H            = TEXT_H_DEF,
    parameter int unsigned BLINK_FRAMES      = 30
) (
    input  logic                            clock_25,
    input  logic                            reset,
    input  logic [PIXEL_DISPLAY_BIT:0]      X,
    input  logic [PIXEL_DISPLAY_BIT:0]      Y,
    input  logic [XS_W*N_FIELDS-1:0]        field_x_start,
    input  logic [LEN_W*N_FIELDS-1:0]       field_len,
    input  logic [BASE_W*N_FIELDS-1:0]      field_rom_base,
    input  logic [N_FIELDS-1:0]             field_blink,
    hud_overlay_gen_if.master               rom,
    output logic                            datarom
);

    localparam int unsigned PW = PIXEL_DISPLAY_BIT + 1;

    localparam logic [PW-1:0] BX0  = PW'(BORDER_X0);
    localparam logic [PW-1:0] BX1  = PW'(BORDER_X1);
    localparam logic [PW-1:0] BY0  = PW'(BORDER_Y0);
    localparam logic [PW-1:0] BY1  = PW'(BORDER_Y1);
    localparam logic [PW-1:0] BX0I = PW'(BORDER_X0 + BORDER_W);
    localparam logic [PW-1:0] BX1I = PW'(BORDER_X1 - BORDER_W);
    localparam logic [PW-1:0] BY0I = PW'(BORDER_Y0 + BORDER_W);
    localparam logic [PW-1:0] BY1I = PW'(BORDER_Y1 - BORDER_W);
    localparam logic [PW-1:0] TY0  = PW'(TEXT_Y0);
    localparam logic [PW-1:0] TY1  = PW'(TEXT_Y0 + TEXT_H - 1);

    logic blink_phase;

    hud_blink_ctr #(
        .PW           (PW),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clock_25      (clock_25),
        .reset         (reset),
        .x_i           (X),
        .y_i           (Y),
        .blink_phase_o (blink_phase)
    );

    logic border;
    logic in_band;

    always_comb begin
        border = (X >= BX0) && (X <= BX1) && (Y >= BY0) && (Y <= BY1) &&
                 ((X < BX0I) || (X > BX1I) || (Y < BY0I) || (Y > BY1I));
        in_band = (Y >= TY0) && (Y <= TY1);
    end

    logic [ROM_X_W-1:0] x_count_q, x_count_d;
    logic [ROM_Y_W-1:0] y_count_q, y_count_d;
    logic               border_q;
    logic               text_en_q, text_en_d;
    logic               hit;
    logic               hit_blink;
    logic [XS_W:0]      x_ext;
    logic [XS_W:0]      f_end;
    field_desc_t        fd;

    // Walk from the top index down so the lowest overlapping field is the last to claim the pixel.
    always_comb begin
        hit       = 1'b0;
        hit_blink = 1'b0;
        x_count_d = '0;
        y_count_d = '0;
        fd        = '0;
        f_end     = '0;
        x_ext     = (XS_W + 1)'(X);
        for (int i = int'(N_FIELDS) - 1; i >= 0; i--) begin
            fd.x_start  = field_x_start[i*XS_W +: XS_W];
            fd.len      = field_len[i*LEN_W +: LEN_W];
            fd.rom_base = field_rom_base[i*BASE_W +: BASE_W];
            f_end       = field_end(fd.x_start, fd.len);
            if (in_band && (fd.len != '0) && (x_ext >= {1'b0, fd.x_start}) && (x_ext < f_end)) begin
                hit       = 1'b1;
                hit_blink = field_blink[i];
                x_count_d = fd.rom_base + ROM_X_W'(x_ext - {1'b0, fd.x_start});
            end
        end
        if (hit) begin
            y_count_d = ROM_Y_W'(Y - TY0);
        end
        text_en_d = hit && (!hit_blink || blink_phase);
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            x_count_q <= '0;
            y_count_q <= '0;
            border_q  <= 1'b0;
            text_en_q <= 1'b0;
        end else begin
            x_count_q <= x_count_d;
            y_count_q <= y_count_d;
            border_q  <= border;
            text_en_q <= text_en_d;
        end
    end

    assign rom.x_count = x_count_q;
    assign rom.y_count = y_count_q;

    logic border_dl;
    logic text_en_dl;

    if (ROM_LATENCY == 0) begin : g_no_dl
        assign border_dl  = border_q;
        assign text_en_dl = text_en_q;
    end else begin : g_dl
        logic [ROM_LATENCY-1:0] border_sr_q;
        logic [ROM_LATENCY-1:0] text_sr_q;

        always_ff @(posedge clock_25) begin
            if (reset) begin
                border_sr_q <= '0;
                text_sr_q   <= '0;
            end else begin
                border_sr_q <= (border_sr_q << 1) | ROM_LATENCY'(border_q);
                text_sr_q   <= (text_sr_q << 1) | ROM_LATENCY'(text_en_q);
            end
        end

        assign border_dl  = border_sr_q[ROM_LATENCY-1];
        assign text_en_dl = text_sr_q[ROM_LATENCY-1];
    end

    logic datarom_q, datarom_d;

    assign datarom_d = border_dl | (text_en_dl & rom.data);

    always_ff @(posedge clock_25) begin
        if (reset) begin
            datarom_q <= 1'b0;
        end else begin
            datarom_q <= datarom_d;
        end
    end

    assign datarom = datarom_q;

endmodule

// File: tb/tb_hud_overlay_gen.sv
// Directed bench for hud_overlay_gen: border, field fetch, wrap, overlap, blink.
module tb_hud_overlay_gen;
    import hud_pkg::*;

    localparam int NX = 300;
    localparam int NY = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [19:0] fxs;
    logic [15:0] flen;
    logic [15:0] fbase;
    logic [1:0]  fblink;
    logic        datarom;

    int checks = 0;
    int errors = 0;

    hud_overlay_gen_if rom_bus ();

    always #20 clk = ~clk;

    hud_overlay_gen #(
        .BLINK_FRAMES (2)
    ) dut (
        .clock_25       (clk),
        .reset          (rst),
        .X              (px),
        .Y              (py),
        .field_x_start  (fxs),
        .field_len      (flen),
        .field_rom_base (fbase),
        .field_blink    (fblink),
        .rom            (rom_bus),
        .datarom        (datarom)
    );

    task automatic set_defaults();
        fxs    = {10'(SCORE_X_START), 10'(TIME_X_START)};
        flen   = {8'(SCORE_LEN), 8'(TIME_LEN)};
        fbase  = {8'(SCORE_ROM_BASE), 8'(TIME_ROM_BASE)};
        fblink = 2'b00;
    endtask

    // Present one pixel for a single cycle, then return to a neutral interior pixel.
    task automatic pix(input int x, input int y);
        px = 10'(x);
        py = 10'(y);
        @(posedge clk);
        #1;
        px = 10'(NX);
        py = 10'(NY);
    endtask

    task automatic tick2();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        px  = 10'd60;
        py  = 10'd40;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rom_bus.x_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_x_count got %0d want 0", rom_bus.x_count);
        end
        checks++;
        if (rom_bus.y_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_y_count got %0d want 0", rom_bus.y_count);
        end
        checks++;
        if (datarom !== 1'b0) begin
            errors++;
            $display("FAIL reset_datarom got %b want 0", datarom);
        end
        rst = 1'b0;
        pix(60, 40);
        @(posedge clk);
        #1;
        checks++;
        if (datarom !== 1'b0) begin
            errors++;
            $display("FAIL reset_refill_early got %b want 0", datarom);
        end
        @(posedge clk);
        #1;
        checks++;
        if (datarom !== 1'b1) begin
            errors++;
            $display("FAIL reset_refill_border got %b want 1", datarom);
        end
    endtask

    task automatic test_border();
        int bx[4] = '{57, 58, 683, 684};
        int by[4] = '{200, 200, 453, 453};
        logic be[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rom_bus.data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix(bx[i], by[i]);
            tick2();
            checks++;
            if (datarom !== be[i]) begin
                errors++;
                $display("FAIL border_%0d_%0d got %b want %b", bx[i], by[i], datarom, be[i]);
            end
        end
    endtask

    task automatic test_field_fetch();
        rom_bus.data = 1'b1;
        pix(362, 465);
        checks++;
        if (rom_bus.x_count !== 8'd62) begin
            errors++;
            $display("FAIL fetch_x_count got %0d want 62", rom_bus.x_count);
        end
        checks++;
        if (rom_bus.y_count !== 4'd5) begin
            errors++;
            $display("FAIL fetch_y_count got %0d want 5", rom_bus.y_count);
        end
        tick2();
        checks++;
        if (datarom !== 1'b1) begin
            errors++;
            $display("FAIL fetch_datarom got %b want 1", datarom);
        end
        rom_bus.data = 1'b0;
        pix(362, 465);
        tick2();
        checks++;
        if (datarom !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data0 got %b want 0", datarom);
        end
        rom_bus.data = 1'b1;
    endtask

    task automatic test_field_boundary();
        rom_bus.data = 1'b1;
        pix(442, 465);
        checks++;
        if (rom_bus.x_count !== 8'd142) begin
            errors++;
            $display("FAIL last_col_x_count got %0d want 142", rom_bus.x_count);
        end
        tick2();
        checks++;
        if (datarom !== 1'b1) begin
            errors++;
            $display("FAIL last_col_datarom got %b want 1", datarom);
        end
        pix(443, 465);
        checks++;
        if (rom_bus.x_count !== 8'd0) begin
            errors++;
            $display("FAIL past_end_x_count got %0d want 0", rom_bus.x_count);
        end
        tick2();
        checks++;
        if (datarom !== 1'b0) begin
            errors++;
            $display("FAIL past_end_datarom got %b want 0", datarom);
        end
        fbase[15:8] = 8'd250;
        pix(372, 465);
        checks++;
        if (rom_bus.x_count !== 8'd4) begin
            errors++;
            $display("FAIL base_wrap_x_count got %0d want 4", rom_bus.x_count);
        end
        set_defaults();
    endtask

    task automatic test_overlap();
        fxs   = {10'd110, 10'd100};
        flen  = {8'd20, 8'd20};
        fbase = {8'd100, 8'd0};
        pix(115, 465);
        checks++;
        if (rom_bus.x_count !== 8'd15) begin
            errors++;
            $display("FAIL overlap_x_count got %0d want 15", rom_bus.x_count);
        end
        pix(125, 475);
        checks++;
        if (rom_bus.x_count !== 8'd115 || rom_bus.y_count !== 4'd15) begin
            errors++;
            $display("FAIL band_last_row got x=%0d y=%0d want x=115 y=15",
                     rom_bus.x_count, rom_bus.y_count);
        end
        pix(115, 476);
        checks++;
        if (rom_bus.x_count !== 8'd0) begin
            errors++;
            $display("FAIL below_band_x_count got %0d want 0", rom_bus.x_count);
        end
        flen[7:0] = 8'd0;
        pix(115, 465);
        checks++;
        if (rom_bus.x_count !== 8'd105) begin
            errors++;
            $display("FAIL len0_disable_x_count got %0d want 105", rom_bus.x_count);
        end
        set_defaults();
    endtask

    task automatic test_blink();
        logic exp1;
        set_defaults();
        fblink       = 2'b10;
        rom_bus.data = 1'b1;
        // Drive the phase to hidden, then reset must bring it back visible.
        pix(0, 0);
        pix(0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) pix(0, 0);
            exp1 = (k < 2) || (k >= 4);
            pix(400, 465);
            tick2();
            checks++;
            if (datarom !== exp1) begin
                errors++;
                $display("FAIL blink_f1_frame%0d got %b want %b", k, datarom, exp1);
            end
            pix(120, 465);
            tick2();
            checks++;
            if (datarom !== 1'b1) begin
                errors++;
                $display("FAIL blink_f0_frame%0d got %b want 1", k, datarom);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        px           = 10'(NX);
        py           = 10'(NY);
        rom_bus.data = 1'b0;
        set_defaults();
        test_reset();
        test_border();
        test_field_fetch();
        test_field_boundary();
        test_overlap();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hud_overlay_gen.md
Name: hud_overlay_gen

Overview:
Parametrised generator for the playfield border and HUD text fields, such as TIME and SCORE. It drives the glyph ROM address (x_count, y_count) and combines the returned ROM bit with the border mask into a single overlay bit, datarom. A delay line of configurable depth keeps datarom aligned with the ROM read latency. It supports N runtime-placed text fields with per-field ROM base and frame-counted blinking. It sits between the VGA timing counters (X, Y) and the pixel colour mux, alongside the snake and food renderers.

Parameters:
PIXEL_DISPLAY_BIT, 9, X/Y are PIXEL_DISPLAY_BIT+1 bits wide
N_FIELDS, 2, number of text fields (1..8)
ROM_LATENCY, 1, cycles from x_count/y_count to valid data (0..3)
BORDER_X0, 53, outer-left border pixel column
BORDER_X1, 683, outer-right border pixel column
BORDER_Y0, 38, outer-top border pixel row
BORDER_Y1, 453, outer-bottom border pixel row
BORDER_W, 5, border thickness in pixels
TEXT_Y0, 460, first row of the text band
TEXT_H, 16, text band height (must be ≤16)
BLINK_FRAMES, 30, frames per blink half-period (≥1)

Ports:
clock_25  in  1  pixel clock
reset  in  1  synchronous, active-high reset
X  in  PIXEL_DISPLAY_BIT+1  current pixel column
Y  in  PIXEL_DISPLAY_BIT+1  current pixel row
field_x_start  in  10*N_FIELDS  start column per field; field i occupies bits [10i+9:10i]
field_len  in  8*N_FIELDS  width in pixels per field; 0 disables the field
field_rom_base  in  8*N_FIELDS  ROM column offset per field
field_blink  in  N_FIELDS  1 = field blinks
data  in  1  glyph ROM output bit
x_count  out  8  ROM column address
y_count  out  4  ROM row address
datarom  out  1  overlay pixel (border OR visible text)

Behaviour:
- Clock and reset: single clock, clock_25. Reset is synchronous and active-high and is sampled only on the posedge of clock_25.
- Reset values: x_count=0, y_count=0, datarom=0, delay line=0, frame counter=0, blink phase=1 (visible).
- Border mask (combinational on X, Y):
  - Asserted when X is in [X0,X1] and Y is in [Y0,Y1], and at least one of: X<X0+W, X>X1-W, Y<Y0+W, Y>Y1-W.
  - All bounds are inclusive.
- Text band: Y in [TEXT_Y0, TEXT_Y0+TEXT_H-1].
- Field hit i:
  - Condition: text band AND field_len[i]≠0 AND field_x_start[i] ≤ X < field_x_start[i]+field_len[i].
  - The sum field_x_start[i]+field_len[i] is computed at 11 bits, with no wrap.
  - If fields overlap, the lowest index wins.
- Stage 1 (registered, 1 cycle after X/Y):
  - On a hit: x_count = field_rom_base[i] + (X - field_x_start[i]), truncated to 8 bits (wraps mod 256). y_count = (Y - TEXT_Y0)[3:0].
  - On no hit, or outside the text band: x_count=0, y_count=0.
  - The border flag and text_en flag are registered alongside.
  - text_en = hit AND (field_blink[i]==0 OR blink_phase==1).
- Delay line: the border and text_en flags pass through ROM_LATENCY further register stages.
- Output stage: datarom = border_d OR (text_en_d AND data). It is registered, so datarom is valid 2+ROM_LATENCY cycles after the corresponding X/Y.
  - With ROM_LATENCY=0 this is 2 cycles; the ROM is then combinational on x_count/y_count.
- Blink:
  - A frame start is the cycle where X==0 and Y==0. This occurs once per frame; the counter increments once per frame start.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - With BLINK_FRAMES=1, the phase toggles every frame.
- Timing of config and phase changes:
  - field_* inputs are sampled every cycle, with no shadowing. Software changes them only during vertical blank.
  - A phase change takes effect on the next stage-1 sample.
- Reset mid-frame: all pipeline flags clear. datarom=0 until the pipeline refills with post-reset pixels. The blink phase restarts visible.
- Border and text overlap: OR'd, so datarom=1.

Decomposition:
- Shared package hud_pkg:
  - Default geometry constants (BORDER_*, TEXT_Y0, TEXT_H).
  - Field descriptor slice widths (10/8/8).
  - Default TIME and SCORE field values: x_start 108/362, len 63/81, rom_base 0/62.
- One sub-module: hud_blink_ctr, holding the frame-start detect, frame counter and phase toggle.
- Field priority encoding, border mask and delay line stay in the top level.

Test Plan:
- Reset held 3 cycles with X=60, Y=40 → x_count=0, y_count=0, datarom=0. After release, datarom=1 at the 2+ROM_LATENCY cycle.
- Border edges with defaults (W=5):
  - X=57, Y=200 → datarom=1; X=58, Y=200 → datarom=0.
  - X=683, Y=453 → datarom=1; X=684, Y=453 → datarom=0.
- Field 1 fetch: field1 = {362, 81, 62}, X=362, Y=465 → one cycle later x_count=62, y_count=5. With data=1 and ROM_LATENCY=1, datarom=1 two cycles after x_count.
- Field boundary and wrap:
  - X=442 → hit; X=443 → x_count=0, datarom=0.
  - rom_base=250, X=x_start+10 → x_count=4.
- Overlap: field0 = {100, 20, 0} and field1 = {110, 20, 100}, X=115 → x_count=15 (field0 wins).
- Blink with BLINK_FRAMES=2 and field_blink=2'b10:
  - Field1 is visible for frames 0–1, masked (datarom=0 despite data=1) for frames 2–3, and visible again from frame 4.
  - Field0 is always visible.
